// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Two-port arbiter and setup/strobe/hold sequencer for a single
//                asynchronous 16-bit SRAM. Port A is the CPU data port
//                (read/write), port B is the instruction-fetch port (read-only).
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int WAIT_CYCLES = 1  // strobe-phase length in cycles, must be >= 1
) (
  input  logic        clk,
  input  logic        rst,         // asynchronous, active-low

  // Port A: CPU data port
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic [15:0] a_rdata,
  output logic        a_ack,

  // Port B: CPU instruction-fetch port
  input  logic        b_req,
  input  logic [15:0] b_addr,
  output logic [15:0] b_rdata,
  output logic        b_ack,

  // SRAM pins
  inout  wire  [15:0] memDataBus,
  output logic [17:0] memAddrBus,
  output logic        memEnable,
  output logic        memRead,
  output logic        memWrite
);

  // Counter wide enough to hold WAIT_CYCLES itself.
  localparam int   c_CNT_W  = $clog2(WAIT_CYCLES + 1);
  localparam logic c_PORT_A = 1'b0;
  localparam logic c_PORT_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;

  logic                 r_port;       // port owning the current access
  logic                 r_lastGrant;  // port served most recently
  logic                 r_we;
  logic [15:0]          r_addr;
  logic [15:0]          r_wdata;
  logic [c_CNT_W-1:0]   r_waitCnt;
  logic [15:0]          r_aRdata;
  logic [15:0]          r_bRdata;

  logic                 w_anyReq;
  logic                 w_grantPort;
  logic                 w_grantWe;
  logic [15:0]          w_grantAddr;
  logic                 w_lastStrobe;
  logic                 w_busDrive;
  logic                 w_readCapture;

  assign w_anyReq      = a_req | b_req;
  assign w_lastStrobe  = (r_waitCnt == c_CNT_W'(1));
  assign w_readCapture = (r_state == S_STROBE) && w_lastStrobe && !r_we;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    w_grantPort = c_PORT_B;
    if (a_req && b_req) begin
      w_grantPort = ~r_lastGrant;
    end else if (a_req) begin
      w_grantPort = c_PORT_A;
    end
    // Port B is read-only, so its direction is always read.
    w_grantWe   = (w_grantPort == c_PORT_A) ? a_we : 1'b0;
    w_grantAddr = (w_grantPort == c_PORT_A) ? a_addr : b_addr;
  end

  // Next-state sequencing: IDLE -> SETUP -> STROBE x WAIT_CYCLES -> DONE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_anyReq) begin
          w_stateNext = S_SETUP;
        end
      end
      S_SETUP: begin
        w_stateNext = S_STROBE;
      end
      S_STROBE: begin
        if (w_lastStrobe) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Pin and ack decode: enable and output-enable span SETUP..DONE so DONE
  // provides hold time; write strobe is confined to STROBE.
  always_comb begin
    memEnable  = 1'b1;
    memRead    = 1'b1;
    memWrite   = 1'b1;
    w_busDrive = 1'b0;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    if (r_state != S_IDLE) begin
      memEnable  = 1'b0;
      memRead    = r_we;       // low only for reads
      w_busDrive = r_we;       // drive only for writes, never alongside OE
    end
    if ((r_state == S_STROBE) && r_we) begin
      memWrite = 1'b0;
    end
    if (r_state == S_DONE) begin
      a_ack = (r_port == c_PORT_A);
      b_ack = (r_port == c_PORT_B);
    end
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Grant latch: owner, direction, address and write data captured in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_port      <= c_PORT_B;
      r_lastGrant <= c_PORT_B;
      r_we        <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
    end else if ((r_state == S_IDLE) && w_anyReq) begin
      r_port      <= w_grantPort;
      r_lastGrant <= w_grantPort;
      r_we        <= w_grantWe;
      r_addr      <= w_grantAddr;
      r_wdata     <= a_wdata;
    end
  end

  // Strobe-phase counter: loaded in SETUP, counts down through STROBE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_waitCnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_waitCnt <= c_CNT_W'(WAIT_CYCLES);
    end else if ((r_state == S_STROBE) && !w_lastStrobe) begin
      r_waitCnt <= r_waitCnt - c_CNT_W'(1);
    end
  end

  // Read data capture at the end of the last strobe cycle, into the owner only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aRdata <= 16'h0000;
      r_bRdata <= 16'h0000;
    end else if (w_readCapture) begin
      if (r_port == c_PORT_A) begin
        r_aRdata <= memDataBus;
      end else begin
        r_bRdata <= memDataBus;
      end
    end
  end

  assign memDataBus = w_busDrive ? r_wdata : 16'hzzzz;
  assign memAddrBus = {2'b00, r_addr};
  assign a_rdata    = r_aRdata;
  assign b_rdata    = r_bRdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Directed, table-driven bench for sram_port_arbiter with a
//                behavioural SRAM model and a WAIT_CYCLES=3 second instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Main instance (WAIT_CYCLES = 1)
  logic        aReq = 1'b0, aWe = 1'b0, bReq = 1'b0;
  logic [15:0] aAddr = '0, aWdata = '0, bAddr = '0;
  logic [15:0] aRdata, bRdata;
  logic        aAck, bAck;
  wire  [15:0] memDataBus;
  logic [17:0] memAddrBus;
  logic        memEnable, memRead, memWrite;

  sram_port_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
    .a_rdata(aRdata), .a_ack(aAck),
    .b_req(bReq), .b_addr(bAddr), .b_rdata(bRdata), .b_ack(bAck),
    .memDataBus(memDataBus), .memAddrBus(memAddrBus),
    .memEnable(memEnable), .memRead(memRead), .memWrite(memWrite)
  );

  // Second instance (WAIT_CYCLES = 3), write-only traffic on port A
  logic        aReq3 = 1'b0;
  logic [15:0] aAddr3 = '0, aWdata3 = '0;
  logic [15:0] aRdata3, bRdata3;
  logic        aAck3, bAck3;
  wire  [15:0] memDataBus3;
  logic [17:0] memAddrBus3;
  logic        memEnable3, memRead3, memWrite3;

  sram_port_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .a_req(aReq3), .a_we(1'b1), .a_addr(aAddr3), .a_wdata(aWdata3),
    .a_rdata(aRdata3), .a_ack(aAck3),
    .b_req(1'b0), .b_addr(16'h0000), .b_rdata(bRdata3), .b_ack(bAck3),
    .memDataBus(memDataBus3), .memAddrBus(memAddrBus3),
    .memEnable(memEnable3), .memRead(memRead3), .memWrite(memWrite3)
  );

  // SRAM model: drives the bus while selected with OE low and WE high;
  // stores on the rising edge of WE. Reset reloads the preset contents.
  logic [15:0] sramMem [0:255];
  assign memDataBus = (!memEnable && !memRead && memWrite) ? sramMem[memAddrBus[7:0]] : 16'hzzzz;

  always @(posedge memWrite or negedge rst) begin
    if (!rst) begin
      sramMem[8'hFF] <= 16'hBEEF;
      sramMem[8'h20] <= 16'h5A5A;
      sramMem[8'h30] <= 16'hC3C3;
    end else if (!memEnable) begin
      sramMem[memAddrBus[7:0]] <= memDataBus;
    end
  end

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        aReq, aWe;
    logic [15:0] aAddr, aWdata;
    logic        bReq;
    logic [15:0] bAddr;
    logic        en, rd, wr;
    logic [17:0] addr;
    logic        aAck, bAck;
    logic [15:0] aRd, bRd;
    logic        chkBus;
    logic [15:0] bus;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic aR, input logic aW, input logic [15:0] aA, input logic [15:0] aD,
    input logic bR, input logic [15:0] bA,
    input logic en, input logic rd, input logic wr, input logic [17:0] ad,
    input logic aK, input logic bK, input logic [15:0] aRd, input logic [15:0] bRd,
    input logic cB, input logic [15:0] bus);
    vec_t v;
    v.aReq = aR; v.aWe = aW; v.aAddr = aA; v.aWdata = aD;
    v.bReq = bR; v.bAddr = bA;
    v.en = en; v.rd = rd; v.wr = wr; v.addr = ad;
    v.aAck = aK; v.bAck = bK; v.aRd = aRd; v.bRd = bRd;
    v.chkBus = cB; v.bus = bus;
    vecs.push_back(v);
  endfunction

  // Bounded run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [12:0] expWr3, expEn3, expAck3;

    // ---- Vector table (one row per cycle, W=1) ----
    //   aReq aWe aAddr    aWdata   bReq bAddr     en rd wr addr       aAck bAck aRd      bRd      chk bus
    // A writes 0x1234 to 0x0010
    add(1,1,16'h0010,16'h1234, 0,16'h0000, 1,1,1,18'h00000, 0,0,16'h0000,16'h0000, 0,16'h0000);
    add(1,1,16'h0010,16'h1234, 0,16'h0000, 0,1,1,18'h00010, 0,0,16'h0000,16'h0000, 1,16'h1234);
    add(1,1,16'h0010,16'h1234, 0,16'h0000, 0,1,0,18'h00010, 0,0,16'h0000,16'h0000, 1,16'h1234);
    add(1,1,16'h0010,16'h1234, 0,16'h0000, 0,1,1,18'h00010, 1,0,16'h0000,16'h0000, 1,16'h1234);
    add(0,0,16'h0000,16'h0000, 0,16'h0000, 1,1,1,18'h00010, 0,0,16'h0000,16'h0000, 0,16'h0000);
    // B reads 0xFFFF (model returns 0xBEEF)
    add(0,0,16'h0000,16'h0000, 1,16'hFFFF, 1,1,1,18'h00010, 0,0,16'h0000,16'h0000, 0,16'h0000);
    add(0,0,16'h0000,16'h0000, 1,16'hFFFF, 0,0,1,18'h0FFFF, 0,0,16'h0000,16'h0000, 0,16'h0000);
    add(0,0,16'h0000,16'h0000, 1,16'hFFFF, 0,0,1,18'h0FFFF, 0,0,16'h0000,16'h0000, 1,16'hBEEF);
    add(0,0,16'h0000,16'h0000, 1,16'hFFFF, 0,0,1,18'h0FFFF, 0,1,16'h0000,16'hBEEF, 1,16'hBEEF);
    add(0,0,16'h0000,16'h0000, 0,16'h0000, 1,1,1,18'h0FFFF, 0,0,16'h0000,16'hBEEF, 0,16'h0000);
    // Continuous contention: A (0x20), B (0x30), A (0x10), B (0xFFFF)
    add(1,0,16'h0020,16'h0000, 1,16'h0030, 1,1,1,18'h0FFFF, 0,0,16'h0000,16'hBEEF, 0,16'h0000);
    add(1,0,16'h0020,16'h0000, 1,16'h0030, 0,0,1,18'h00020, 0,0,16'h0000,16'hBEEF, 0,16'h0000);
    add(1,0,16'h0020,16'h0000, 1,16'h0030, 0,0,1,18'h00020, 0,0,16'h0000,16'hBEEF, 1,16'h5A5A);
    add(1,0,16'h0020,16'h0000, 1,16'h0030, 0,0,1,18'h00020, 1,0,16'h5A5A,16'hBEEF, 1,16'h5A5A);
    add(1,0,16'h0020,16'h0000, 1,16'h0030, 1,1,1,18'h00020, 0,0,16'h5A5A,16'hBEEF, 0,16'h0000);
    add(1,0,16'h0020,16'h0000, 1,16'h0030, 0,0,1,18'h00030, 0,0,16'h5A5A,16'hBEEF, 0,16'h0000);
    add(1,0,16'h0020,16'h0000, 1,16'h0030, 0,0,1,18'h00030, 0,0,16'h5A5A,16'hBEEF, 1,16'hC3C3);
    add(1,0,16'h0020,16'h0000, 1,16'h0030, 0,0,1,18'h00030, 0,1,16'h5A5A,16'hC3C3, 1,16'hC3C3);
    add(1,0,16'h0010,16'h0000, 1,16'h0030, 1,1,1,18'h00030, 0,0,16'h5A5A,16'hC3C3, 0,16'h0000);
    add(1,0,16'h0010,16'h0000, 1,16'h0030, 0,0,1,18'h00010, 0,0,16'h5A5A,16'hC3C3, 0,16'h0000);
    add(1,0,16'h0010,16'h0000, 1,16'h0030, 0,0,1,18'h00010, 0,0,16'h5A5A,16'hC3C3, 1,16'h1234);
    add(1,0,16'h0010,16'h0000, 1,16'h0030, 0,0,1,18'h00010, 1,0,16'h1234,16'hC3C3, 1,16'h1234);
    add(0,0,16'h0000,16'h0000, 1,16'hFFFF, 1,1,1,18'h00010, 0,0,16'h1234,16'hC3C3, 0,16'h0000);
    add(0,0,16'h0000,16'h0000, 1,16'hFFFF, 0,0,1,18'h0FFFF, 0,0,16'h1234,16'hC3C3, 0,16'h0000);
    add(0,0,16'h0000,16'h0000, 1,16'hFFFF, 0,0,1,18'h0FFFF, 0,0,16'h1234,16'hC3C3, 1,16'hBEEF);
    add(0,0,16'h0000,16'h0000, 1,16'hFFFF, 0,0,1,18'h0FFFF, 0,1,16'h1234,16'hBEEF, 1,16'hBEEF);
    add(0,0,16'h0000,16'h0000, 0,16'h0000, 1,1,1,18'h0FFFF, 0,0,16'h1234,16'hBEEF, 0,16'h0000);

    // ---- Reset state ----
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst memEnable", 32'(memEnable), 32'h1);
    check("rst memRead",   32'(memRead),   32'h1);
    check("rst memWrite",  32'(memWrite),  32'h1);
    check("rst memAddrBus", 32'(memAddrBus), 32'h0);
    check("rst a_ack",     32'(aAck),      32'h0);
    check("rst b_ack",     32'(bAck),      32'h0);
    check("rst a_rdata",   32'(aRdata),    32'h0);
    check("rst b_rdata",   32'(bRdata),    32'h0);
    check("rst W3 memEnable", 32'(memEnable3), 32'h1);
    check("rst W3 memWrite",  32'(memWrite3),  32'h1);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // ---- Table-driven cycles ----
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      aReq = vecs[i].aReq; aWe = vecs[i].aWe; aAddr = vecs[i].aAddr; aWdata = vecs[i].aWdata;
      bReq = vecs[i].bReq; bAddr = vecs[i].bAddr;
      @(negedge clk);
      check($sformatf("row%0d memEnable", i), 32'(memEnable), 32'(vecs[i].en));
      check($sformatf("row%0d memRead", i),   32'(memRead),   32'(vecs[i].rd));
      check($sformatf("row%0d memWrite", i),  32'(memWrite),  32'(vecs[i].wr));
      check($sformatf("row%0d memAddrBus", i), 32'(memAddrBus), 32'(vecs[i].addr));
      check($sformatf("row%0d a_ack", i),     32'(aAck),      32'(vecs[i].aAck));
      check($sformatf("row%0d b_ack", i),     32'(bAck),      32'(vecs[i].bAck));
      check($sformatf("row%0d a_rdata", i),   32'(aRdata),    32'(vecs[i].aRd));
      check($sformatf("row%0d b_rdata", i),   32'(bRdata),    32'(vecs[i].bRd));
      if (vecs[i].chkBus) begin
        check($sformatf("row%0d memDataBus", i), 32'(memDataBus), 32'(vecs[i].bus));
      end
    end

    // ---- Reset in the middle of an A write strobe ----
    @(posedge clk); #1;
    aReq = 1'b1; aWe = 1'b1; aAddr = 16'h0040; aWdata = 16'hAAAA; bReq = 1'b0;
    @(posedge clk); #1;                       // SETUP
    @(posedge clk); #1;                       // STROBE
    @(negedge clk);
    check("midrst pre memWrite", 32'(memWrite), 32'h0);
    #1 rst = 1'b0;
    #1;
    check("midrst memWrite",  32'(memWrite),  32'h1);
    check("midrst memEnable", 32'(memEnable), 32'h1);
    check("midrst memRead",   32'(memRead),   32'h1);
    check("midrst a_ack",     32'(aAck),      32'h0);
    aReq = 1'b0; aWe = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("postrst%0d a_ack", k),     32'(aAck),      32'h0);
      check($sformatf("postrst%0d memEnable", k), 32'(memEnable), 32'h1);
    end
    check("postrst memAddrBus", 32'(memAddrBus), 32'h0);
    check("postrst a_rdata",    32'(aRdata),     32'h0);
    check("postrst b_rdata",    32'(bRdata),     32'h0);

    // ---- First tie after reset goes to A ----
    @(posedge clk); #1;
    aReq = 1'b1; aWe = 1'b0; aAddr = 16'h0020; bReq = 1'b1; bAddr = 16'h0030;
    @(posedge clk); #1;
    @(negedge clk);
    check("tie setup memAddrBus", 32'(memAddrBus), 32'h00020);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("tie a_ack",   32'(aAck),   32'h1);
    check("tie b_ack",   32'(bAck),   32'h0);
    check("tie a_rdata", 32'(aRdata), 32'h5A5A);
    @(posedge clk); #1;
    aReq = 1'b0; bReq = 1'b0;
    @(posedge clk); #1;

    // ---- WAIT_CYCLES=3: held A write, two back-to-back accesses ----
    expWr3  = 13'b1100011100011;
    expEn3  = 13'b1000001000001;
    expAck3 = 13'b0100000100000;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      aReq3   = (c < 12);
      aAddr3  = 16'h00F0;
      aWdata3 = (c < 6) ? 16'h0F0F : 16'hF00F;
      @(negedge clk);
      check($sformatf("w3 c%0d memWrite", c),  32'(memWrite3),  32'(expWr3[c]));
      check($sformatf("w3 c%0d memEnable", c), 32'(memEnable3), 32'(expEn3[c]));
      check($sformatf("w3 c%0d a_ack", c),     32'(aAck3),      32'(expAck3[c]));
      if (!expEn3[c]) begin
        check($sformatf("w3 c%0d memDataBus", c), 32'(memDataBus3),
              (c < 6) ? 32'h0F0F : 32'hF00F);
        check($sformatf("w3 c%0d memRead", c), 32'(memRead3), 32'h1);
      end
      if (c == 1) begin
        check("w3 memAddrBus", 32'(memAddrBus3), 32'h000F0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
